// File: rtl/rupt_arbiter.sv
// rupt_arbiter: interrupt priority arbiter and sequencer for the instruction
// sequence register path. It captures request edges as pending bits, grants
// the highest-priority pending source (index 0 first) at an allowed
// instruction boundary, and holds interrupt-in-progress (IIP) until resume.
//
// Optional build macro: RUPT_LOCK_EN adds a lock watchdog that raises RLOCK
// after LOCK_LIMIT instruction boundaries spent inside one interrupt. Without
// the macro RLOCK is tied low, and the port list is the same in both builds.
//
// Sequencer handshake: the grant is requested by holding RUPTOR_n low in
// GRANT. KRPT is a one-cycle acknowledge that is honoured only in GRANT (it
// retires the pending bit and moves to SERVICE). RELPLS is a one-cycle resume
// pulse that is honoured only in SERVICE (it returns to IDLE). Either pulse
// arriving in any other state is dropped with no side effect.

module rupt_arbiter #(
    parameter int          NRUPT      = 10,
    parameter logic [11:0] VEC_BASE   = 12'o4000,
    parameter int          VEC_STRIDE = 4,
    parameter logic [15:0] LOCK_LIMIT = 16'd4096
) (
    input  logic             SIM_CLK,
    input  logic             SIM_RST,
    input  logic             GOJAM,
    input  logic             T12,
    input  logic             NISQ,
    input  logic             INHINT,
    input  logic             EXT,
    input  logic             OVNHRP,
    input  logic [NRUPT-1:0] RUPT_REQ,
    input  logic             KRPT,
    input  logic             RELPLS,
    output logic             RUPTOR_n,
    output logic             IIP,
    output logic [11:0]      RPTADDR,
    output logic [NRUPT-1:0] RPTSEL,
    output logic [NRUPT-1:0] PEND,
    output logic             RLOCK
);

    localparam int SW = (NRUPT > 1) ? $clog2(NRUPT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [NRUPT-1:0] req_prev_q, req_prev_d;
    logic [NRUPT-1:0] pend_q, pend_d;
    logic [SW-1:0]    sel_q, sel_d;

    logic [NRUPT-1:0] rise;
    logic [NRUPT-1:0] clr_mask;
    logic [NRUPT-1:0] sel_onehot;
    logic [SW-1:0]    pick_idx;
    logic [11:0]      vec_addr;
    logic             allow;
    logic             in_rupt;
    logic             to_idle;

    // Rising-edge detect on requests and the boundary qualification. allow
    // looks only at registered pending bits, so an edge landing on the same
    // cycle as T12 waits for the following boundary.
    always_comb begin
        rise  = RUPT_REQ & ~req_prev_q;
        allow = T12 & NISQ & ~INHINT & ~EXT & ~OVNHRP & (|pend_q);
    end

    // Fixed priority: the lowest set index of the pending register wins.
    always_comb begin
        pick_idx = '0;
        for (int i = NRUPT - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                pick_idx = SW'(i);
            end
        end
    end

    // One-hot decode of the frozen selection, shared by RPTSEL and PEND clear.
    always_comb begin
        sel_onehot = '0;
        for (int i = 0; i < NRUPT; i++) begin
            sel_onehot[i] = (sel_q == SW'(i));
        end
    end

    // Vector address of the selected source, wrapped to the 12-bit address.
    always_comb begin
        vec_addr = VEC_BASE + 12'(VEC_STRIDE) * 12'(sel_q);
    end

    // Sequencer next state; the selection is latched once and held until IDLE.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        clr_mask = '0;
        case (state_q)
            ST_IDLE: begin
                if (allow) begin
                    sel_d   = pick_idx;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (KRPT) begin
                    clr_mask = sel_onehot;
                    state_d  = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (RELPLS) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (GOJAM) begin
            state_d  = ST_IDLE;
            sel_d    = '0;
            clr_mask = '0;
        end
    end

    // Pending register: a new edge outranks a same-cycle acknowledge clear.
    always_comb begin
        req_prev_d = RUPT_REQ;
        pend_d     = (pend_q & ~clr_mask) | rise;
        if (GOJAM) begin
            req_prev_d = '0;
            pend_d     = '0;
        end
    end

    // Core state registers.
    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            state_q    <= ST_IDLE;
            sel_q      <= '0;
            req_prev_q <= '0;
            pend_q     <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            req_prev_q <= req_prev_d;
            pend_q     <= pend_d;
        end
    end

    // Outputs decoded from the registered state; vector fields read zero in IDLE.
    always_comb begin
        in_rupt  = (state_q != ST_IDLE);
        to_idle  = in_rupt && (state_d == ST_IDLE);
        RUPTOR_n = (state_q != ST_GRANT);
        IIP      = in_rupt;
        RPTSEL   = in_rupt ? sel_onehot : '0;
        RPTADDR  = in_rupt ? vec_addr : 12'd0;
        PEND     = pend_q;
    end

`ifdef RUPT_LOCK_EN
    logic [15:0] lock_cnt_q, lock_cnt_d;
    logic        rlock_q, rlock_d;

    // Watchdog: count boundaries spent in an interrupt; the alarm is sticky
    // until GOJAM or reset even though the count restarts at every IDLE.
    always_comb begin
        lock_cnt_d = lock_cnt_q;
        rlock_d    = rlock_q;
        if (T12 && in_rupt && (lock_cnt_q != LOCK_LIMIT)) begin
            lock_cnt_d = lock_cnt_q + 16'd1;
            if ((lock_cnt_q + 16'd1) == LOCK_LIMIT) begin
                rlock_d = 1'b1;
            end
        end
        if (to_idle) begin
            lock_cnt_d = '0;
        end
        if (GOJAM) begin
            lock_cnt_d = '0;
            rlock_d    = 1'b0;
        end
    end

    // Watchdog registers.
    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            lock_cnt_q <= '0;
            rlock_q    <= 1'b0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
            rlock_q    <= rlock_d;
        end
    end

    assign RLOCK = rlock_q;
`else
    logic lock_unused;

    // No watchdog in this build; the limit and transition flag have no load.
    assign lock_unused = (^LOCK_LIMIT) ^ to_idle;
    assign RLOCK       = 1'b0;
`endif

endmodule

// File: tb/tb_rupt_arbiter.sv
// Directed bench for rupt_arbiter. Each expected grant (one-hot select plus
// vector address) is queued when the boundary is driven; a monitor pops and
// compares whenever RUPTOR_n falls. Status outputs are compared directly.

module tb_rupt_arbiter;

    localparam int NR = 10;
    localparam int W  = NR + 12;

`ifdef RUPT_LOCK_EN
    localparam logic LOCK_BUILT = 1'b1;
`else
    localparam logic LOCK_BUILT = 1'b0;
`endif

    logic          SIM_CLK = 1'b0;
    logic          SIM_RST;
    logic          GOJAM, T12, NISQ, INHINT, EXT, OVNHRP, KRPT, RELPLS;
    logic [NR-1:0] RUPT_REQ;
    logic          RUPTOR_n, IIP, RLOCK;
    logic [11:0]   RPTADDR;
    logic [NR-1:0] RPTSEL, PEND;

    logic [W-1:0]  exp_q[$];
    int            n_vec = 0;
    int            n_err = 0;

    rupt_arbiter #(
        .NRUPT(NR),
        .VEC_BASE(12'o4000),
        .VEC_STRIDE(4),
        .LOCK_LIMIT(16'd4)
    ) dut (
        .SIM_CLK(SIM_CLK),
        .SIM_RST(SIM_RST),
        .GOJAM(GOJAM),
        .T12(T12),
        .NISQ(NISQ),
        .INHINT(INHINT),
        .EXT(EXT),
        .OVNHRP(OVNHRP),
        .RUPT_REQ(RUPT_REQ),
        .KRPT(KRPT),
        .RELPLS(RELPLS),
        .RUPTOR_n(RUPTOR_n),
        .IIP(IIP),
        .RPTADDR(RPTADDR),
        .RPTSEL(RPTSEL),
        .PEND(PEND),
        .RLOCK(RLOCK)
    );

    // Clock and run-time guard.
    always #5 SIM_CLK = ~SIM_CLK;

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t, required finish", $time);
        $fatal(1, "timeout");
    end

    // Driver tasks: inputs change 1 time unit after the rising edge.
    task automatic step();
        @(posedge SIM_CLK);
        #1;
    endtask

    task automatic pulse_req(input logic [NR-1:0] mask);
        RUPT_REQ = mask;
        step();
        RUPT_REQ = '0;
    endtask

    task automatic boundary(input logic grant_expected, input logic [NR-1:0] e_sel,
                            input logic [11:0] e_addr);
        if (grant_expected) exp_q.push_back({e_sel, e_addr});
        T12 = 1'b1;
        step();
        T12 = 1'b0;
    endtask

    task automatic pulse_krpt();
        KRPT = 1'b1;
        step();
        KRPT = 1'b0;
    endtask

    task automatic pulse_relpls();
        RELPLS = 1'b1;
        step();
        RELPLS = 1'b0;
    endtask

    task automatic pulse_gojam();
        GOJAM = 1'b1;
        step();
        GOJAM = 1'b0;
    endtask

    // Scoreboard comparison helpers.
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic check_status(input string name, input logic e_ruptor_n, input logic e_iip,
                                input logic [NR-1:0] e_sel, input logic [11:0] e_addr,
                                input logic [NR-1:0] e_pend);
        check({name, ".ruptor_n"}, 32'(RUPTOR_n), 32'(e_ruptor_n));
        check({name, ".iip"},      32'(IIP),      32'(e_iip));
        check({name, ".rptsel"},   32'(RPTSEL),   32'(e_sel));
        check({name, ".rptaddr"},  32'(RPTADDR),  32'(e_addr));
        check({name, ".pend"},     32'(PEND),     32'(e_pend));
    endtask

    // Monitor: every falling RUPTOR_n presents a grant to compare with the queue.
    initial begin
        logic         prev_ruptor_n;
        logic [W-1:0] e;
        prev_ruptor_n = 1'b1;
        forever begin
            @(negedge SIM_CLK);
            if (prev_ruptor_n && !RUPTOR_n) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL grant_unexpected: got sel=0x%0h addr=%0o, required no grant",
                             RPTSEL, RPTADDR);
                end else begin
                    e = exp_q.pop_front();
                    if ({RPTSEL, RPTADDR} !== e) begin
                        n_err++;
                        $display("FAIL grant: got sel=0x%0h addr=%0o, required sel=0x%0h addr=%0o",
                                 RPTSEL, RPTADDR, e[W-1:12], e[11:0]);
                    end
                end
            end
            prev_ruptor_n = RUPTOR_n;
        end
    end

    // Directed stimulus.
    initial begin
        SIM_RST  = 1'b0;
        GOJAM    = 1'b0;
        T12      = 1'b0;
        NISQ     = 1'b1;
        INHINT   = 1'b0;
        EXT      = 1'b0;
        OVNHRP   = 1'b0;
        KRPT     = 1'b0;
        RELPLS   = 1'b0;
        RUPT_REQ = '0;

        repeat (3) step();
        check_status("reset", 1'b1, 1'b0, '0, 12'o0, '0);
        check("reset.rlock", 32'(RLOCK), 32'd0);
        SIM_RST = 1'b1;
        step();

        // Single request on source 3.
        pulse_req(10'h008);
        check("src3.pend", 32'(PEND), 32'h008);
        boundary(1'b1, 10'h008, 12'o4014);
        check_status("src3.grant", 1'b0, 1'b1, 10'h008, 12'o4014, 10'h008);
        pulse_krpt();
        check_status("src3.service", 1'b1, 1'b1, 10'h008, 12'o4014, 10'h000);
        pulse_relpls();
        check_status("src3.idle", 1'b1, 1'b0, '0, 12'o0, '0);

        // Sources 2 and 7 pending; each block in turn suppresses the grant.
        pulse_req(10'h084);
        INHINT = 1'b1;
        boundary(1'b0, '0, 12'o0);
        INHINT = 1'b0;
        check_status("blk.inhint", 1'b1, 1'b0, '0, 12'o0, 10'h084);
        EXT = 1'b1;
        boundary(1'b0, '0, 12'o0);
        EXT = 1'b0;
        check("blk.ext.iip", 32'(IIP), 32'd0);
        OVNHRP = 1'b1;
        boundary(1'b0, '0, 12'o0);
        OVNHRP = 1'b0;
        check("blk.ovnhrp.iip", 32'(IIP), 32'd0);
        NISQ = 1'b0;
        boundary(1'b0, '0, 12'o0);
        NISQ = 1'b1;
        check("blk.nisq.iip", 32'(IIP), 32'd0);
        boundary(1'b1, 10'h004, 12'o4010);
        check_status("src2.grant", 1'b0, 1'b1, 10'h004, 12'o4010, 10'h084);
        pulse_krpt();
        check_status("src2.service", 1'b1, 1'b1, 10'h004, 12'o4010, 10'h080);
        pulse_relpls();
        boundary(1'b1, 10'h080, 12'o4034);
        check_status("src7.grant", 1'b0, 1'b1, 10'h080, 12'o4034, 10'h080);
        pulse_krpt();
        pulse_relpls();
        check_status("src7.idle", 1'b1, 1'b0, '0, 12'o0, '0);

        // No preemption: source 0 arrives while source 5 is granted.
        pulse_req(10'h020);
        boundary(1'b1, 10'h020, 12'o4024);
        pulse_req(10'h001);
        check_status("nopre.grant", 1'b0, 1'b1, 10'h020, 12'o4024, 10'h021);
        pulse_krpt();
        check_status("nopre.service", 1'b1, 1'b1, 10'h020, 12'o4024, 10'h001);
        pulse_relpls();
        boundary(1'b1, 10'h001, 12'o4000);
        check("nopre.src0.sel", 32'(RPTSEL), 32'h001);
        pulse_krpt();
        pulse_relpls();

        // Rise on the selected bit in the KRPT cycle keeps it pending.
        pulse_req(10'h010);
        boundary(1'b1, 10'h010, 12'o4020);
        RUPT_REQ = 10'h010;
        pulse_krpt();
        RUPT_REQ = '0;
        check_status("setwins", 1'b1, 1'b1, 10'h010, 12'o4020, 10'h010);
        pulse_krpt();
        check_status("krpt_in_service", 1'b1, 1'b1, 10'h010, 12'o4020, 10'h010);
        pulse_relpls();
        pulse_krpt();
        check_status("krpt_in_idle", 1'b1, 1'b0, '0, 12'o0, 10'h010);
        boundary(1'b1, 10'h010, 12'o4020);
        pulse_relpls();
        check_status("relpls_in_grant", 1'b0, 1'b1, 10'h010, 12'o4020, 10'h010);
        pulse_krpt();
        pulse_relpls();

        // GOJAM in SERVICE with everything pending.
        pulse_req(10'h3FF);
        boundary(1'b1, 10'h001, 12'o4000);
        pulse_krpt();
        pulse_req(10'h001);
        check_status("gojam.pre", 1'b1, 1'b1, 10'h001, 12'o4000, 10'h3FF);
        pulse_gojam();
        check_status("gojam.post", 1'b1, 1'b0, '0, 12'o0, '0);

        // Asynchronous reset in GRANT takes effect between clock edges.
        pulse_req(10'h040);
        boundary(1'b1, 10'h040, 12'o4030);
        check("arst.pre.ruptor_n", 32'(RUPTOR_n), 32'd0);
        @(negedge SIM_CLK);
        #2;
        SIM_RST = 1'b0;
        #1;
        check_status("arst.post", 1'b1, 1'b0, '0, 12'o0, '0);
        step();
        SIM_RST = 1'b1;
        step();

        // Lock watchdog (limit 4): four boundaries in SERVICE without resume.
        pulse_req(10'h002);
        boundary(1'b1, 10'h002, 12'o4004);
        pulse_krpt();
        boundary(1'b0, '0, 12'o0);
        boundary(1'b0, '0, 12'o0);
        boundary(1'b0, '0, 12'o0);
        check("lock.after3", 32'(RLOCK), 32'd0);
        boundary(1'b0, '0, 12'o0);
        check("lock.after4", 32'(RLOCK), 32'(LOCK_BUILT));
        pulse_relpls();
        check("lock.after_relpls", 32'(RLOCK), 32'(LOCK_BUILT));
        check("lock.idle.iip", 32'(IIP), 32'd0);
        pulse_gojam();
        check("lock.after_gojam", 32'(RLOCK), 32'd0);

        repeat (3) step();
        check("grant_queue_left", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
